// File: rtl/pe_addr_pkg.sv
// ============================================================================
// pe_addr_pkg
// Shared types and default sizing for the per-PE address controller.
//   pe_state_e   : per-channel state (IDLE / RUN / DONE)
//   DEF_NUM_PE   : default number of PE channels
//   DEF_ADDR_W   : default address width per channel
//   DEF_LEN_W    : default pass-length counter width
// ============================================================================
package pe_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pe_state_e;

    localparam int DEF_NUM_PE = 16;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_LEN_W  = 13;

endpackage

// File: rtl/pe_addr_ctrl_if.sv
// ============================================================================
// pe_addr_ctrl_if
// Bus between the layer sequencer (master) and the address controller (slave).
//   en, valid       : global step enable and per-channel step requests
//   cfg_*           : pass configuration, captured when cfg_load is high
//   addr            : packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   addr_vld        : channel i is presenting a live address
//   pass_done       : one-cycle pulse when channel i finishes a pass
//   all_done, busy  : array-wide status
// ============================================================================
interface pe_addr_ctrl_if #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 13
);
    logic                       en;
    logic [NUM_PE-1:0]          valid;
    logic                       cfg_load;
    logic [ADDR_W-1:0]          cfg_base;
    logic [ADDR_W-1:0]          cfg_stride;
    logic [LEN_W-1:0]           cfg_len;
    logic                       cfg_wrap;
    logic [NUM_PE*ADDR_W-1:0]   addr;
    logic [NUM_PE-1:0]          addr_vld;
    logic [NUM_PE-1:0]          pass_done;
    logic                       all_done;
    logic                       busy;

    modport master (
        output en, valid, cfg_load, cfg_base, cfg_stride, cfg_len, cfg_wrap,
        input  addr, addr_vld, pass_done, all_done, busy
    );

    modport slave (
        input  en, valid, cfg_load, cfg_base, cfg_stride, cfg_len, cfg_wrap,
        output addr, addr_vld, pass_done, all_done, busy
    );
endinterface

// File: rtl/pe_addr_chan.sv
// ============================================================================
// pe_addr_chan
// One PE channel: IDLE -> RUN -> DONE state machine stepping a strided
// address through a window of programmed length.
//   clk, reset    : clock and synchronous active-high reset
//   cfg_load      : restart the channel from cfg_base
//   cfg_base      : live base address, used on the loading edge
//   cfg_len_zero  : the length being loaded is zero (go straight to DONE)
//   base_q        : latched base, used when a wrapping pass restarts
//   stride_q      : latched address increment
//   last_idx      : latched length minus one
//   wrap_q        : latched wrap mode
//   step          : en && valid for this channel
//   addr          : current address
//   addr_vld      : channel is in RUN
//   pass_done     : registered one-cycle end-of-pass pulse
//   done          : channel is in DONE
// ============================================================================
module pe_addr_chan
    import pe_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              cfg_len_zero,
    input  logic [ADDR_W-1:0] base_q,
    input  logic [ADDR_W-1:0] stride_q,
    input  logic [LEN_W-1:0]  last_idx,
    input  logic              wrap_q,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_vld,
    output logic              pass_done,
    output logic              done
);

    pe_state_e         state;
    logic [LEN_W-1:0]  idx;

    // Channel state, address and index. A load wins over a step arriving on
    // the same edge, and the new base is presented straight away so the
    // consumer sees it with no extra cycle. pass_done defaults low every
    // cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            idx       <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (cfg_load) begin
                addr  <= cfg_base;
                idx   <= '0;
                state <= cfg_len_zero ? DONE : RUN;
            end else if (state == RUN && step) begin
                if (idx == last_idx) begin
                    pass_done <= 1'b1;
                    if (wrap_q) begin
                        addr <= base_q;
                        idx  <= '0;
                    end else begin
                        state <= DONE;
                    end
                end else begin
                    addr <= addr + stride_q;
                    idx  <= idx + LEN_W'(1);
                end
            end
        end
    end

    assign addr_vld = (state == RUN);
    assign done     = (state == DONE);

endmodule

// File: rtl/pe_addr_ctrl.sv
// ============================================================================
// pe_addr_ctrl
// Array of NUM_PE independent strided address generators sharing a single
// configuration captured on cfg_load.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of pe_addr_ctrl_if (steps, config, addresses,
//                per-channel status, array-wide all_done / busy)
// ============================================================================
module pe_addr_ctrl
    import pe_addr_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    pe_addr_ctrl_if.slave  bus
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  len_q;
    logic              wrap_q;
    logic [LEN_W-1:0]  last_idx;
    logic              cfg_len_zero;
    logic [NUM_PE-1:0] chan_done;

    // Shared configuration latch. Later changes on the cfg_* inputs are
    // ignored until the next load, so the sequencer may prepare the next
    // layer's settings while the current pass is still running.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            wrap_q   <= 1'b0;
        end else if (bus.cfg_load) begin
            base_q   <= bus.cfg_base;
            stride_q <= bus.cfg_stride;
            len_q    <= bus.cfg_len;
            wrap_q   <= bus.cfg_wrap;
        end
    end

    // A zero length never reaches RUN, so the underflow of len_q - 1 in that
    // case is never observed by a channel.
    assign last_idx     = len_q - LEN_W'(1);
    assign cfg_len_zero = (bus.cfg_len == '0);

    for (genvar i = 0; i < NUM_PE; i++) begin : g_chan
        pe_addr_chan #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .cfg_load     (bus.cfg_load),
            .cfg_base     (bus.cfg_base),
            .cfg_len_zero (cfg_len_zero),
            .base_q       (base_q),
            .stride_q     (stride_q),
            .last_idx     (last_idx),
            .wrap_q       (wrap_q),
            .step         (bus.en & bus.valid[i]),
            .addr         (bus.addr[i*ADDR_W +: ADDR_W]),
            .addr_vld     (bus.addr_vld[i]),
            .pass_done    (bus.pass_done[i]),
            .done         (chan_done[i])
        );
    end

    assign bus.all_done = &chan_done;
    assign bus.busy     = |bus.addr_vld;

endmodule

// File: tb/tb_pe_addr_ctrl.sv
// ============================================================================
// tb_pe_addr_ctrl
// Scoreboard bench: every driven cycle runs a behavioural model of the array,
// pushes the expected outputs into a queue, and the entry is popped and
// compared once the DUT has clocked that cycle. Scenario-specific constant
// checks back up the model.
// ============================================================================
module tb_pe_addr_ctrl;

    localparam int NP = 16;
    localparam int AW = 13;
    localparam int LW = 13;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    typedef struct {
        logic [NP*AW-1:0] addr;
        logic [NP-1:0]    vld;
        logic [NP-1:0]    pd;
        logic             all_done;
        logic             busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pe_addr_ctrl_if #(.NUM_PE(NP), .ADDR_W(AW), .LEN_W(LW)) bus ();

    pe_addr_ctrl #(.NUM_PE(NP), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    string       testName   = "init";

    // Reference model state
    int           mState [NP];
    logic [AW-1:0] mAddr [NP];
    int           mIdx   [NP];
    logic [NP-1:0] mPd;
    logic [AW-1:0] mBase;
    logic [AW-1:0] mStride;
    int           mLen;
    bit           mWrap;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s/%s: got %h expected %h", testName, tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] laneAddr(input int i);
        return bus.addr[i*AW +: AW];
    endfunction

    task automatic modelUpdate(input bit rst, input bit e, input logic [NP-1:0] v,
                               input bit ld, input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input logic [LW-1:0] l, input bit w);
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                mState[i] = S_IDLE;
                mAddr[i]  = '0;
                mIdx[i]   = 0;
            end
            mPd = '0;
        end else begin
            mPd = '0;
            if (ld) begin
                mBase = b; mStride = s; mLen = int'(l); mWrap = w;
                for (int i = 0; i < NP; i++) begin
                    mAddr[i]  = b;
                    mIdx[i]   = 0;
                    mState[i] = (l == 0) ? S_DONE : S_RUN;
                end
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (mState[i] == S_RUN && e && v[i]) begin
                        if (mIdx[i] + 1 == mLen) begin
                            mPd[i] = 1'b1;
                            if (mWrap) begin
                                mAddr[i] = mBase;
                                mIdx[i]  = 0;
                            end else begin
                                mState[i] = S_DONE;
                            end
                        end else begin
                            mAddr[i] = mAddr[i] + mStride;
                            mIdx[i]  = mIdx[i] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // Drives one cycle of stimulus, queues the model's expectation, clocks the
    // DUT and compares the popped entry against its outputs.
    task automatic applyStimulus(input bit rst, input bit e, input logic [NP-1:0] v,
                                 input bit ld, input logic [AW-1:0] b, input logic [AW-1:0] s,
                                 input logic [LW-1:0] l, input bit w);
        exp_t ex;
        exp_t got;
        reset          = rst;
        bus.en         = e;
        bus.valid      = v;
        bus.cfg_load   = ld;
        bus.cfg_base   = b;
        bus.cfg_stride = s;
        bus.cfg_len    = l;
        bus.cfg_wrap   = w;
        modelUpdate(rst, e, v, ld, b, s, l, w);
        ex.all_done = 1'b1;
        ex.busy     = 1'b0;
        for (int i = 0; i < NP; i++) begin
            ex.addr[i*AW +: AW] = mAddr[i];
            ex.vld[i]           = (mState[i] == S_RUN);
            ex.pd[i]            = mPd[i];
            if (mState[i] != S_DONE) ex.all_done = 1'b0;
            if (mState[i] == S_RUN)  ex.busy     = 1'b1;
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("addr",      256'(bus.addr),      256'(got.addr));
        checkOutput("addr_vld",  256'(bus.addr_vld),  256'(got.vld));
        checkOutput("pass_done", 256'(bus.pass_done), 256'(got.pd));
        checkOutput("all_done",  256'(bus.all_done),  256'(got.all_done));
        checkOutput("busy",      256'(bus.busy),      256'(got.busy));
    endtask

    // Plain step cycle with no load and reset low.
    task automatic stepCycle(input bit e, input logic [NP-1:0] v);
        applyStimulus(1'b0, e, v, 1'b0, 13'h0AA, 13'h005, 13'd7, 1'b1);
    endtask

    task automatic loadCycle(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [LW-1:0] l, input bit w);
        applyStimulus(1'b0, 1'b1, '1, 1'b1, b, s, l, w);
    endtask

    initial begin
        mPd = '0; mBase = '0; mStride = '0; mLen = 0; mWrap = 0;

        // Reset then idle with steps requested everywhere
        testName = "reset_idle";
        applyStimulus(1'b1, 1'b1, '1, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '1, 1'b0, '0, '0, '0, 1'b0);
        stepCycle(1'b1, '1);
        stepCycle(1'b1, '1);
        checkOutput("idle lane3 addr", 256'(laneAddr(3)), 256'(13'h000));
        checkOutput("idle busy",       256'(bus.busy),    256'(1'b0));

        // One-shot on lane 0 only
        testName = "oneshot";
        loadCycle(13'h010, 13'd4, 13'd3, 1'b0);
        checkOutput("load lane0", 256'(laneAddr(0)), 256'(13'h010));
        stepCycle(1'b1, 16'h0001);
        checkOutput("step1 lane0", 256'(laneAddr(0)), 256'(13'h014));
        stepCycle(1'b1, 16'h0001);
        checkOutput("step2 lane0", 256'(laneAddr(0)), 256'(13'h018));
        stepCycle(1'b1, 16'h0001);
        checkOutput("final pd0",    256'(bus.pass_done[0]), 256'(1'b1));
        checkOutput("final vld0",   256'(bus.addr_vld[0]),  256'(1'b0));
        checkOutput("final lane0",  256'(laneAddr(0)),      256'(13'h018));
        checkOutput("other lane7",  256'(laneAddr(7)),      256'(13'h010));
        stepCycle(1'b1, 16'h0001);
        checkOutput("pd0 one pulse", 256'(bus.pass_done[0]), 256'(1'b0));
        checkOutput("done hold",     256'(laneAddr(0)),      256'(13'h018));

        // Wrap mode with address overflow
        testName = "wrap";
        loadCycle(13'h1FFC, 13'd4, 13'd2, 1'b1);
        checkOutput("w0", 256'(laneAddr(15)), 256'(13'h1FFC));
        stepCycle(1'b1, '1);
        checkOutput("w1", 256'(laneAddr(15)), 256'(13'h0000));
        stepCycle(1'b1, '1);
        checkOutput("w2",    256'(laneAddr(15)),     256'(13'h1FFC));
        checkOutput("w2 pd", 256'(bus.pass_done),    256'(16'hFFFF));
        stepCycle(1'b1, '1);
        checkOutput("w3", 256'(laneAddr(15)), 256'(13'h0000));
        stepCycle(1'b1, '1);
        checkOutput("w4",    256'(laneAddr(15)),  256'(13'h1FFC));
        checkOutput("w4 ad", 256'(bus.all_done),  256'(1'b0));

        // Enable gating freezes and resumes
        testName = "enable";
        loadCycle(13'h100, 13'd3, 13'd8, 1'b0);
        stepCycle(1'b1, '1);
        stepCycle(1'b1, '1);
        for (int k = 0; k < 5; k++) stepCycle(1'b0, '1);
        checkOutput("frozen", 256'(laneAddr(5)), 256'(13'h106));
        stepCycle(1'b1, '1);
        checkOutput("resume", 256'(laneAddr(5)), 256'(13'h109));
        stepCycle(1'b1, 16'h5A5A);
        stepCycle(1'b1, 16'h00F0);

        // all_done after one-shot, then zero-length load
        testName = "all_done";
        loadCycle(13'h020, 13'd1, 13'd2, 1'b0);
        stepCycle(1'b1, '1);
        stepCycle(1'b1, '1);
        checkOutput("ad set",  256'(bus.all_done), 256'(1'b1));
        checkOutput("ad busy", 256'(bus.busy),     256'(1'b0));
        loadCycle(13'h033, 13'd1, 13'd0, 1'b1);
        checkOutput("len0 ad", 256'(bus.all_done),  256'(1'b1));
        checkOutput("len0 pd", 256'(bus.pass_done), 256'(16'h0000));
        stepCycle(1'b1, '1);

        // Load beats a coincident final step; reset aborts a pass
        testName = "priority";
        loadCycle(13'h040, 13'd2, 13'd2, 1'b0);
        stepCycle(1'b1, '1);
        loadCycle(13'h080, 13'd2, 13'd2, 1'b0);
        checkOutput("prio addr", 256'(laneAddr(2)),   256'(13'h080));
        checkOutput("prio pd",   256'(bus.pass_done), 256'(16'h0000));
        stepCycle(1'b1, '1);
        checkOutput("prio idx0", 256'(laneAddr(2)),   256'(13'h082));
        checkOutput("prio vld",  256'(bus.addr_vld),  256'(16'hFFFF));
        applyStimulus(1'b1, 1'b1, '1, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("rst addr", 256'(bus.addr),     256'(0));
        checkOutput("rst busy", 256'(bus.busy),     256'(1'b0));
        stepCycle(1'b1, '1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pe_addr_ctrl.md
# pe_addr_ctrl

Parametrised per-PE address generator for the PE array: NUM_PE independent channels, each stepping a strided read address through a programmed window whenever its `valid` lane is granted. It replaces the fixed 16-lane, free-running address controller. It adds programmable base, stride and length, wrap or one-shot mode, per-channel pass completion and an array-wide done flag. It sits between the layer sequencer, which configures it, and the PE buffer read ports, which consume `addr`.

## Interface
- NUM_PE, 16, number of PE channels (≥1)
- ADDR_W, 13, address width per channel
- LEN_W, 13, width of pass-length counter
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  global step enable
- valid  in  NUM_PE  per-channel step request
- cfg_load  in  1  load configuration into all channels and start
- cfg_base  in  ADDR_W  first address of pass
- cfg_stride  in  ADDR_W  address increment per step
- cfg_len  in  LEN_W  addresses per pass
- cfg_wrap  in  1  1 = restart pass at end; 0 = stop (one-shot)
- addr  out  NUM_PE*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- addr_vld  out  NUM_PE  channel i is in RUN
- pass_done  out  NUM_PE  one-cycle pulse: channel i finished a pass
- all_done  out  1  every channel in DONE
- busy  out  1  any channel in RUN

## Operation
- Per-channel FSM: IDLE → RUN → DONE. Registers per channel: addr, idx (LEN_W), state. cfg_wrap is latched once, shared by all channels.
- Reset: state=IDLE, addr=0, idx=0, pass_done=0. Combinational outputs then read addr_vld=0, all_done=0, busy=0.
- cfg_load, any state: addr←cfg_base, idx←0, wrap latched. State←RUN, or DONE if cfg_len==0. cfg_load overrides any step in the same cycle.
- Step condition for channel i: state==RUN && en && valid[i]. Channels step independently.
- On step with idx≠cfg_len−1 (latched len): addr←addr+stride mod 2^ADDR_W (wraps silently), idx←idx+1.
- On step with idx==len−1: pass_done[i]←1 for one cycle.
  - Wrap mode: addr←base, idx←0, stay in RUN.
  - One-shot mode: state←DONE, addr held at the last address.
- en=0 or valid[i]=0: channel holds addr and idx (no reset-on-disable).
- DONE and IDLE ignore steps. Only cfg_load or reset leaves DONE.
- addr_vld[i] = (state==RUN).
- all_done = every channel DONE. Never asserts in wrap mode unless cfg_len==0.
- busy = OR of addr_vld.
- base, stride and len are latched at cfg_load. Later cfg_* changes have no effect until the next cfg_load.

## Timing
- cfg_load sampled at edge k → addr=base and addr_vld=1 from after edge k. Zero-cycle address presentation.
- Step sampled at edge k → new addr after edge k. One address per cycle per channel, max.
- pass_done[i] is registered: high the cycle after the edge that accepted the final step.
- all_done and busy are combinational from state registers. No extra latency.
- Reset asserted mid-pass: all channels return to IDLE at that edge, and any pending pass_done is cleared.

## Structure
- Package pe_addr_pkg: state enum (IDLE/RUN/DONE, 2-bit) and default parameter constants.
- Sub-module pe_addr_chan holds one channel's FSM, addr and idx. The top instantiates NUM_PE copies via generate, plus the shared config latch and the all_done/busy reduction.

## Test plan
- Reset then idle: reset 2 cycles, en=1, valid=all-ones → addr=0, addr_vld=0, busy=0, all_done=0 throughout.
- One-shot single lane: base=0x010, stride=4, len=3, wrap=0, load, then valid=0x0001 held. Required results:
  - lane0 addr 0x010→0x014→0x018.
  - pass_done[0] pulses once, lane0 enters DONE and holds 0x018.
  - Other lanes remain at 0x010 in RUN.
- Wrap and overflow: base=0x1FFC, stride=4, len=2, wrap=1, valid=all-ones, 5 steps. Required results:
  - addr sequence 0x1FFC, 0x0000, 0x1FFC, 0x0000, 0x1FFC.
  - pass_done pulses after steps 2 and 4.
  - all_done stays 0.
- Enable gating: mid-pass, en=0 for 5 cycles with valid=all-ones → addresses frozen; resume with en=1 and continue from the frozen value.
- all_done and cfg_len=0:
  - One-shot len=2 on all lanes, valid=all-ones → all_done=1 after 2 steps, busy=0.
  - Then load with len=0 → all_done=1 immediately, no pass_done.
- Priority: cfg_load coincident with a final step → addr=new base, idx=0, no pass_done. Reset during RUN → IDLE next cycle, all outputs at reset values.
